// File: rtl/ch_advert_tx.sv
// Cluster-head advertisement transmitter.
// Serializes CHE (hdr, id, hops, qv, csum) or HB (hdr, id, csum) packets onto a
// valid/ready word stream, repeats each packet REPEAT times with GAP_CYCLES idle
// cycles between copies, then pulses done.
module ch_advert_tx #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned REPEAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  che_req,
    input  logic                  hb_req,
    input  logic [WORD_WIDTH-1:0] node_ID,
    input  logic [WORD_WIDTH-1:0] node_Hops,
    input  logic [WORD_WIDTH-1:0] node_QValue,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned CW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT - 1);

    localparam logic [WORD_WIDTH-1:0] HDR_CHE = WORD_WIDTH'(16'h1005);
    localparam logic [WORD_WIDTH-1:0] HDR_HB  = WORD_WIDTH'(16'h2003);

    typedef enum logic [2:0] {
        StIdle, StHdr, StId, StHops, StQv, StCsum, StGap, StDone
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_che_q, pend_che_d;
    logic                    pend_hb_q, pend_hb_d;
    logic                    sh_hb_q, sh_hb_d;
    logic [WORD_WIDTH-1:0]   sh_id_q, sh_id_d;
    logic [WORD_WIDTH-1:0]   sh_hops_q, sh_hops_d;
    logic [WORD_WIDTH-1:0]   sh_qv_q, sh_qv_d;
    logic [CW-1:0]           copy_q, copy_d;
    logic [GW-1:0]           gap_q, gap_d;

    logic                    hs;
    logic                    start;
    logic [WORD_WIDTH-1:0]   hops_sat;
    logic [WORD_WIDTH-1:0]   hdr_word;
    logic [WORD_WIDTH-1:0]   csum_word;

    assign hs       = tx_valid && tx_ready;
    assign hops_sat = (node_Hops == {WORD_WIDTH{1'b1}}) ? node_Hops : node_Hops + 1'b1;
    assign hdr_word = sh_hb_q ? HDR_HB : HDR_CHE;
    // HB packets carry no hops/qv, so they drop out of the checksum.
    assign csum_word = hdr_word ^ sh_id_q ^ (sh_hb_q ? '0 : (sh_hops_q ^ sh_qv_q));

    // State, pending-request and shadow registers; synchronous reset wins over requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pend_che_q <= 1'b0;
            pend_hb_q  <= 1'b0;
            sh_hb_q    <= 1'b0;
            sh_id_q    <= '0;
            sh_hops_q  <= '0;
            sh_qv_q    <= '0;
            copy_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_che_q <= pend_che_d;
            pend_hb_q  <= pend_hb_d;
            sh_hb_q    <= sh_hb_d;
            sh_id_q    <= sh_id_d;
            sh_hops_q  <= sh_hops_d;
            sh_qv_q    <= sh_qv_d;
            copy_q     <= copy_d;
            gap_q      <= gap_d;
        end
    end

    // Next-state: request arbitration (HB first), word sequencing, copy/gap counting.
    always_comb begin
        state_d    = state_q;
        pend_che_d = pend_che_q | che_req;
        pend_hb_d  = pend_hb_q | hb_req;
        sh_hb_d    = sh_hb_q;
        sh_id_d    = sh_id_q;
        sh_hops_d  = sh_hops_q;
        sh_qv_d    = sh_qv_q;
        copy_d     = copy_q;
        gap_d      = gap_q;
        start      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend_hb_q || hb_req) begin
                    start     = 1'b1;
                    sh_hb_d   = 1'b1;
                    pend_hb_d = 1'b0;
                end else if (pend_che_q || che_req) begin
                    start      = 1'b1;
                    sh_hb_d    = 1'b0;
                    pend_che_d = 1'b0;
                end
                if (start) begin
                    sh_id_d   = node_ID;
                    sh_hops_d = hops_sat;
                    sh_qv_d   = node_QValue;
                    copy_d    = '0;
                    state_d   = StHdr;
                end
            end
            StHdr:  if (hs) state_d = StId;
            StId:   if (hs) state_d = sh_hb_q ? StCsum : StHops;
            StHops: if (hs) state_d = StQv;
            StQv:   if (hs) state_d = StCsum;
            StCsum: begin
                if (hs) begin
                    if (copy_q == REP_LAST) begin
                        state_d = StDone;
                    end else begin
                        copy_d  = copy_q + 1'b1;
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = StHdr;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the registered state so they stay stable under backpressure.
    always_comb begin
        tx_data  = '0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        unique case (state_q)
            StHdr:  begin tx_valid = 1'b1; tx_data = hdr_word;  end
            StId:   begin tx_valid = 1'b1; tx_data = sh_id_q;   end
            StHops: begin tx_valid = 1'b1; tx_data = sh_hops_q; end
            StQv:   begin tx_valid = 1'b1; tx_data = sh_qv_q;   end
            StCsum: begin tx_valid = 1'b1; tx_data = csum_word; tx_last = 1'b1; end
            default: ;
        endcase
    end

endmodule
